// File: rtl/bram_port_arbiter.sv
// Round-robin two-requester arbiter in front of a single-port BRAM.
// Registers one command per cycle onto the BRAM port and returns read data to the issuing requester.
module bram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ena_A,
    output logic              wea_A,
    output logic [ADDR_W-1:0] addra_A,
    output logic [DATA_W-1:0] dina_A,
    input  logic [DATA_W-1:0] douta_A
);

    // Stage 0 lines up with ena_A; stage RD_LAT lines up with douta_A valid.
    localparam int DEPTH = RD_LAT + 1;

    logic              prio;
    logic              acc0;
    logic              acc1;
    logic              acc;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DEPTH-1:0]  tag_rd;
    logic [DEPTH-1:0]  tag_own;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    assign gnt0 = rst_n & req0 & (~req1 | ~prio);
    assign gnt1 = rst_n & req1 & (~req0 | prio);

    assign acc0 = req0 & gnt0;
    assign acc1 = req1 & gnt1;
    assign acc  = acc0 | acc1;

    assign sel_we    = acc1 ? we1    : we0;
    assign sel_addr  = acc1 ? addr1  : addr0;
    assign sel_wdata = acc1 ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            ena_A   <= 1'b0;
            wea_A   <= 1'b0;
            addra_A <= '0;
            dina_A  <= '0;
        end else begin
            if (acc0) begin
                prio <= 1'b1;
            end else if (acc1) begin
                prio <= 1'b0;
            end
            ena_A <= acc;
            wea_A <= acc & sel_we;
            if (acc) begin
                addra_A <= sel_addr;
                dina_A  <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd  <= '0;
            tag_own <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            tag_rd  <= {tag_rd[DEPTH-2:0], acc & ~sel_we};
            tag_own <= {tag_own[DEPTH-2:0], acc1};
            rvalid0 <= tag_rd[DEPTH-1] & ~tag_own[DEPTH-1];
            rvalid1 <= tag_rd[DEPTH-1] & tag_own[DEPTH-1];
            if (tag_rd[DEPTH-1] && !tag_own[DEPTH-1]) begin
                rdata0 <= douta_A;
            end
            if (tag_rd[DEPTH-1] && tag_own[DEPTH-1]) begin
                rdata1 <= douta_A;
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: one instance with a 1-cycle BRAM model, one with a 2-cycle model.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;

    // DUT A (RD_LAT = 1)
    logic        req0, req1, we0, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        ena_a, wea_a;
    logic [4:0]  addra_a;
    logic [31:0] dina_a, douta_a;
    logic [31:0] mem_a [32];

    // DUT B (RD_LAT = 2), only requester 0 used
    logic        b_req0, b_we0;
    logic [4:0]  b_addr0;
    logic [31:0] b_wdata0;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic        ena_b, wea_b;
    logic [4:0]  addra_b;
    logic [31:0] dina_b, douta_b, douta_b1;
    logic [31:0] mem_b [32];

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ena_A(ena_a), .wea_A(wea_a), .addra_A(addra_a), .dina_A(dina_a),
        .douta_A(douta_a)
    );

    bram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .RD_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
        .addr0(b_addr0), .addr1(5'd0), .wdata0(b_wdata0), .wdata1(32'd0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .ena_A(ena_b), .wea_A(wea_b), .addra_A(addra_b), .dina_A(dina_b),
        .douta_A(douta_b)
    );

    // BRAM models: 1-cycle and 2-cycle read latency
    always @(posedge clk) begin
        if (ena_a) begin
            if (wea_a) mem_a[addra_a] <= dina_a;
            else       douta_a <= mem_a[addra_a];
        end
    end

    always @(posedge clk) begin
        if (ena_b) begin
            if (wea_b) mem_b[addra_b] <= dina_b;
            else       douta_b1 <= mem_b[addra_b];
        end
        douta_b <= douta_b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          idx0, idx1, seen;
    logic [4:0]  exp_addr [6];

    initial begin
        exp_addr = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        req1 = 1'b0; we1 = 1'b0; addr1 = 5'd0; wdata1 = 32'd0;
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 5'd0; b_wdata0 = 32'd0;

        // reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_ena", {31'd0, ena_a}, 32'd0);
        chk("rst_wea", {31'd0, wea_a}, 32'd0);
        chk("rst_addra", {27'd0, addra_a}, 32'd0);
        chk("rst_dina", dina_a, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_gnt0", {30'd0, gnt1, gnt0}, 32'd1);

        // single requester write then read of address 0
        tick();
        we0 = 1'b0;
        @(negedge clk);
        chk("wr_ena_wea", {30'd0, ena_a, wea_a}, 32'd3);
        chk("wr_addra", {27'd0, addra_a}, 32'd0);
        chk("wr_dina", dina_a, 32'hFFFF_FFFF);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("rd_ena_wea", {30'd0, ena_a, wea_a}, 32'd2);
        tick();
        @(negedge clk);
        chk("rd_idle_ena", {31'd0, ena_a}, 32'd0);
        chk("rd_early", {30'd0, rvalid1, rvalid0}, 32'd0);
        tick();
        @(negedge clk);
        chk("rd_rvalid", {30'd0, rvalid1, rvalid0}, 32'd1);
        chk("rd_rdata0", rdata0, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        chk("rd_pulse", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rd_hold", rdata0, 32'hFFFF_FFFF);

        // requester 1 alone: moves prio back to 0
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd7; wdata1 = 32'h77;
        @(negedge clk);
        chk("r1_alone_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        tick();
        req1 = 1'b0;

        // round robin under contention
        idx0 = 0; idx1 = 0;
        req0 = 1'b1; we0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            addr0 = 5'(1 + idx0); wdata0 = 32'(1 + idx0);
            addr1 = 5'(4 + idx1); wdata1 = 32'(4 + idx1);
            @(negedge clk);
            if (i < 6) chk($sformatf("rr_gnt%0d", i), {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) begin
                chk($sformatf("rr_ena%0d", i - 1), {30'd0, ena_a, wea_a}, 32'd3);
                chk($sformatf("rr_addr%0d", i - 1), {27'd0, addra_a}, {27'd0, exp_addr[i-1]});
            end
            tick();
            if (i % 2 == 0) idx0++; else idx1++;
            if (idx0 == 3) req0 = 1'b0;
            if (idx1 == 3) req1 = 1'b0;
        end

        // interleaved reads: r0 reads addr 4, r1 reads addr 1
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd1;
        @(negedge clk);
        chk("il_gnt_a", {30'd0, gnt1, gnt0}, 32'd1);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("il_gnt_b", {30'd0, gnt1, gnt0}, 32'd2);
        tick();
        req1 = 1'b0;
        @(negedge clk);
        chk("il_none", {30'd0, rvalid1, rvalid0}, 32'd0);
        tick();
        @(negedge clk);
        chk("il_rv0", {30'd0, rvalid1, rvalid0}, 32'd1);
        chk("il_rdata0", rdata0, 32'h4);
        tick();
        @(negedge clk);
        chk("il_rv1", {30'd0, rvalid1, rvalid0}, 32'd2);
        chk("il_rdata1", rdata1, 32'h1);
        tick();
        @(negedge clk);
        chk("il_done", {30'd0, rvalid1, rvalid0}, 32'd0);

        // reset mid-read
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd2;
        tick();
        req0 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_ena", {31'd0, ena_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        chk("mr_prio", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            if (rvalid0) seen++;
        end
        chk("mr_no_rvalid", 32'(seen), 32'd0);

        // RD_LAT = 2 instance: write then read
        b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 5'd3; b_wdata0 = 32'hA5A5_0F0F;
        tick();
        b_we0 = 1'b0;
        tick();
        b_req0 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("l2_early", {31'd0, b_rvalid0}, 32'd0);
        tick();
        @(negedge clk);
        chk("l2_rvalid", {30'd0, b_rvalid1, b_rvalid0}, 32'd1);
        chk("l2_rdata", b_rdata0, 32'hA5A5_0F0F);
        tick();
        @(negedge clk);
        chk("l2_pulse", {31'd0, b_rvalid0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
